// File: rtl/pin_driver.sv
// Turns one-cycle rise/fall request pulses into a clean, dwell-limited pin level.
// Define PIN_DRIVER_NOISE_INJECT_EN to add a bounce (new/old/new) on every pin change.
module pin_driver #(
  parameter int   counterwidth = 3,
  parameter int   waittime     = 3,
  parameter int   depth        = 4,
  parameter logic initlevel    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       positiveedge,
  input  logic       negativeedge,
  output logic       pin,
  output logic       busy,
  output logic       full,
  output logic       dropped,
  output logic [1:0] state_dbg
);

  localparam int ptrw = $clog2(depth);
  localparam int cntw = $clog2(depth + 1);
  localparam logic [cntw-1:0]         depth_c = cntw'(depth);
  localparam logic [counterwidth-1:0] wait_c  = counterwidth'(waittime);

`ifdef PIN_DRIVER_NOISE_INJECT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GLITCH1 = 2'd2, GLITCH2 = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;
`endif

  state_t                  state, state_next;
  logic [counterwidth-1:0] counter, counter_next;
  logic                    pin_next;
  logic [depth-1:0]        mem;
  logic [ptrw-1:0]         rptr, wptr;
  logic [cntw-1:0]         count;
  logic                    single, head, pop, push;

  // Requests are fire-and-forget pulses with no ready: a request is accepted
  // when it is the only one that cycle and a slot exists (or frees by a pop
  // on the same edge); otherwise it is refused and dropped pulses next cycle.
  always_comb begin
    single       = positiveedge ^ negativeedge;
    head         = mem[rptr];
    pop          = (state == IDLE) && (count != '0);
    push         = single && ((count != depth_c) || pop);
    state_next   = state;
    counter_next = counter;
    pin_next     = pin;
    case (state)
      IDLE: begin
        // A popped level equal to the pin is redundant and simply discarded.
        if (pop && (head != pin)) begin
          pin_next     = head;
          counter_next = '0;
`ifdef PIN_DRIVER_NOISE_INJECT_EN
          state_next   = GLITCH1;
`else
          state_next   = HOLD;
`endif
        end
      end
      HOLD: begin
        if (counter != wait_c) counter_next = counter + 1'b1;
        if (counter_next == wait_c) state_next = IDLE;
      end
`ifdef PIN_DRIVER_NOISE_INJECT_EN
      // The change is always non-redundant, so the old level is ~pin.
      GLITCH1: begin
        pin_next   = ~pin;
        state_next = GLITCH2;
      end
      GLITCH2: begin
        pin_next     = ~pin;
        counter_next = '0;
        state_next   = HOLD;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      pin     <= initlevel;
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      pin     <= pin_next;
      if (pop)  rptr <= rptr + 1'b1;
      if (push) wptr <= wptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      dropped <= (positiveedge && negativeedge) || (single && !push);
    end
  end

  // Queue storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wptr] <= positiveedge;
  end

  assign busy      = (count != '0) || (state != IDLE);
  assign full      = (count == depth_c);
  assign state_dbg = state;

endmodule
